dla_toggle_event_receiver: RTL and testbench



---
 rtl/dla_toggle_event_receiver.sv | 107 ++++++++++
 tb/tb_dla_toggle_event_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dla_toggle_event_receiver.sv
// dla_toggle_event_receiver
//
// Destination-domain consumer of a toggle-encoded event crossing. Every
// transition of the synchronized toggle is one event. Events are buffered in
// a saturating pending counter and handed out one at a time over valid/ready.
// Each consumed event flips the acknowledge toggle that goes back to the source.
//
// Optional feature macro: DLA_TOGGLE_RX_OVERFLOW_EN adds a sticky o_overflow
// flag that is set when an event is dropped at a full counter.
//
// Parameters:
//   COUNT_WIDTH  pending counter width (1..16); holds up to 2^COUNT_WIDTH-1 events
//
// Ports:
//   clk           destination-domain clock
//   i_sclrn       synchronous active-low reset
//   i_toggle      synchronized event toggle
//   o_valid       at least one event pending
//   i_ready       consumer accepts one event while o_valid is high
//   o_pending     current pending-event count
//   o_ack_toggle  flips once per consumed event
//   o_overflow    sticky drop flag (only with DLA_TOGGLE_RX_OVERFLOW_EN)

module dla_toggle_event_receiver #(
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   i_sclrn,
  input  logic                   i_toggle,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [COUNT_WIDTH-1:0] o_pending,
  output logic                   o_ack_toggle
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
  ,
  output logic                   o_overflow
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  logic                   toggle_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ack_q, ack_d;
  logic                   evt;
  logic                   cons;
  logic                   at_max;
  logic                   drop;

  assign evt    = i_toggle ^ toggle_q;
  assign cons   = o_valid & i_ready;
  assign at_max = (count_q == CountMax);
  assign drop   = evt & ~cons & at_max;

  // Tracks the input even in reset so releasing reset never sees a phantom edge.
  always_ff @(posedge clk) begin
    toggle_q <= i_toggle;
  end

  always_comb begin
    count_d = count_q;
    ack_d   = ack_q;
    if (evt && !cons) begin
      if (!at_max) begin
        count_d = count_q + CountOne;
      end
    end else if (cons && !evt) begin
      count_d = count_q - CountOne;
    end
    if (cons) begin
      ack_d = ~ack_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_sclrn) begin
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ack_q   <= ack_d;
    end
  end

  assign o_valid      = (count_q != '0);
  assign o_pending    = count_q;
  assign o_ack_toggle = ack_q;

`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (!i_sclrn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_dla_toggle_event_receiver.sv
// Self-checking bench for dla_toggle_event_receiver. Drives a default-width
// instance and a COUNT_WIDTH=2 instance from the same inputs and checks both
// against an event-counting reference model, plus directed expectations.

module tb_dla_toggle_event_receiver;

  logic       clk = 1'b0;
  logic       sclrn;
  logic       tog;
  logic       rdy;
  logic       valid4, valid2;
  logic [3:0] pend4;
  logic [1:0] pend2;
  logic       ack4, ack2;
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
  logic       ovf4, ovf2;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state: pending counts, acknowledgements consumed (parity),
  // dropped-event flags, previous toggle level.
  int p4 = 0, p2 = 0;
  int nack4 = 0, nack2 = 0;
  bit dropped4 = 0, dropped2 = 0;
  bit prev_tog = 0;

  always #5 clk = ~clk;

  dla_toggle_event_receiver u_dut4 (
    .clk          (clk),
    .i_sclrn      (sclrn),
    .i_toggle     (tog),
    .o_valid      (valid4),
    .i_ready      (rdy),
    .o_pending    (pend4),
    .o_ack_toggle (ack4)
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
    ,
    .o_overflow   (ovf4)
`endif
  );

  dla_toggle_event_receiver #(
    .COUNT_WIDTH (2)
  ) u_dut2 (
    .clk          (clk),
    .i_sclrn      (sclrn),
    .i_toggle     (tog),
    .o_valid      (valid2),
    .i_ready      (rdy),
    .o_pending    (pend2),
    .o_ack_toggle (ack2)
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
    ,
    .o_overflow   (ovf2)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_one(inout int p, inout int nack, inout bit dropped, input int cap,
                           input bit evt, input bit r, input bit rstn);
    bit take;
    if (!rstn) begin
      p = 0;
      nack = 0;
      dropped = 0;
    end else begin
      take = (p > 0) && r;
      if (take) nack = nack + 1;
      if (take) p = p - 1;
      if (evt) begin
        if (p < cap) p = p + 1;
        else dropped = 1;
      end
    end
  endtask

  task automatic check_model();
    check("valid4", int'(valid4), int'(p4 != 0));
    check("pend4", int'(pend4), p4);
    check("ack4", int'(ack4), nack4 % 2);
    check("valid2", int'(valid2), int'(p2 != 0));
    check("pend2", int'(pend2), p2);
    check("ack2", int'(ack2), nack2 % 2);
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
    check("ovf4", int'(ovf4), int'(dropped4));
    check("ovf2", int'(ovf2), int'(dropped2));
`endif
  endtask

  // Apply inputs, advance one clock edge, update model, compare everything.
  task automatic cycle(input bit t, input bit r, input bit rstn);
    bit evt;
    tog   = t;
    rdy   = r;
    sclrn = rstn;
    @(posedge clk);
    evt = t ^ prev_tog;
    prev_tog = t;
    model_one(p4, nack4, dropped4, 15, evt, r, rstn);
    model_one(p2, nack2, dropped2, 3, evt, r, rstn);
    #1;
    check_model();
  endtask

  initial begin
    tog   = 1'b0;
    rdy   = 1'b0;
    sclrn = 1'b0;

    // Reset with toggle high, release, no spurious valid.
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      check("rst_pend4", int'(pend4), 0);
      check("rst_ack4", int'(ack4), 0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 1);
      check("post_rst_valid4", int'(valid4), 0);
      check("post_rst_valid2", int'(valid2), 0);
    end

    // Single event, then one consume.
    cycle(0, 0, 1);
    check("single_valid", int'(valid4), 1);
    check("single_pend", int'(pend4), 1);
    cycle(0, 1, 1);
    check("single_cons_valid", int'(valid4), 0);
    check("single_cons_pend", int'(pend4), 0);
    check("single_cons_ack", int'(ack4), 1);

    // Burst of three, then drain over three cycles.
    cycle(0, 0, 0);
    cycle(1, 0, 1);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    check("burst_pend4", int'(pend4), 3);
    check("burst_pend2", int'(pend2), 3);
    cycle(1, 1, 1);
    check("drain_ack_a", int'(ack4), 1);
    cycle(1, 1, 1);
    check("drain_ack_b", int'(ack4), 0);
    cycle(1, 1, 1);
    check("drain_ack_c", int'(ack4), 1);
    check("drain_pend", int'(pend4), 0);

    // Simultaneous event and consume at a count of one.
    cycle(0, 0, 1);
    check("simul_pre_pend", int'(pend4), 1);
    cycle(1, 1, 1);
    check("simul_pend", int'(pend4), 1);
    check("simul_valid", int'(valid4), 1);
    check("simul_ack", int'(ack4), 0);

    // Saturation of the 2-bit instance.
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(((i % 2) == 0) ? 1'b0 : 1'b1, 0, 1);
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
      check("sat_ovf2", int'(ovf2), int'(i >= 3));
      check("sat_ovf4", int'(ovf4), 0);
`endif
    end
    check("sat_pend2", int'(pend2), 3);
    check("sat_pend4", int'(pend4), 5);
    // At max: event plus consume leaves the count unchanged.
    cycle(1, 1, 1);
    check("sat_both_pend2", int'(pend2), 3);
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    check("sat_drain_pend2", int'(pend2), 1);
`ifdef DLA_TOGGLE_RX_OVERFLOW_EN
    check("sat_ovf_sticky", int'(ovf2), 1);
`endif

    // Reset mid-operation.
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 1, 1);
    check("mid_pre_pend", int'(pend4), 2);
    check("mid_pre_ack", int'(ack4), 1);
    cycle(0, 0, 0);
    check("mid_pend", int'(pend4), 0);
    check("mid_valid", int'(valid4), 0);
    check("mid_ack", int'(ack4), 0);
    cycle(1, 0, 1);
    check("mid_new_pend", int'(pend4), 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bit t, r, rn;
      t  = ($urandom_range(0, 99) < 60) ? ~prev_tog : prev_tog;
      r  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
      rn = ($urandom_range(0, 99) != 0);
      cycle(t, r, rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
